// File: rtl/cla_result_checker_pkg.sv
// Shared types and limits for the CLA result checker.
package cla_chk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE,
      ST_HALT
   } chk_state_t;

   localparam int SETTLE_MAX = 15;

endpackage

// File: rtl/cla_result_checker_if.sv
// Vector handshake plus the adder response lines seen by the checker.
interface cla_result_checker_if #(
   parameter int WIDTH = 4
);
   logic             vec_valid;
   logic             ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [WIDTH-1:0] s;
   logic             cout;

   // master: stimulus source together with the adder under check
   modport master (output vec_valid, a, b, cin, s, cout, input ready);
   modport slave  (input vec_valid, a, b, cin, s, cout, output ready);
endinterface

// File: rtl/cla_result_checker_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  q <= '0;
      else if (clr)                q <= '0;
      else if (inc && !(&q))       q <= q + W'(1);
   end

endmodule

// File: rtl/cla_result_checker.sv
// Holds each accepted adder vector, waits SETTLE cycles, samples {cout,s} and
// compares it to a behavioural golden sum; keeps pass/fail stats and first failure.
module cla_result_checker
   import cla_chk_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 stop_on_fail,
   input  logic [CNT_W-1:0]     num_vectors,
   cla_result_checker_if.slave  vif,
   output logic                 busy,
   output logic                 done,
   output logic                 halted,
   output logic [CNT_W-1:0]     pass_cnt,
   output logic [CNT_W-1:0]     fail_cnt,
   output logic [WIDTH-1:0]     fail_a,
   output logic [WIDTH-1:0]     fail_b,
   output logic                 fail_cin,
   output logic [WIDTH-1:0]     fail_s,
   output logic                 fail_cout,
   output logic                 fail_seen
);

   localparam int             SCW         = $clog2(SETTLE_MAX + 1);
   localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);

   chk_state_t       state, state_nx;
   logic             ready_q;
   logic [WIDTH-1:0] a_h, b_h, s_h;
   logic             cin_h, cout_h;
   logic [SCW-1:0]   scnt;
   logic [WIDTH:0]   exp_sum;
   logic             match, accept, in_check, pass_inc, fail_inc, sat_hit;
   logic [CNT_W:0]   total_nx;

   assign vif.ready = ready_q;
   assign accept    = ready_q && vif.vec_valid && !start;
   assign in_check  = (state == ST_CHECK) && !start;

   assign exp_sum  = {1'b0, a_h} + {1'b0, b_h} + {{WIDTH{1'b0}}, cin_h};
   assign match    = ({cout_h, s_h} == exp_sum);
   assign pass_inc = in_check && match;
   assign fail_inc = in_check && !match;

   // Post-update total; a saturated counter contributes no increment.
   assign sat_hit  = match ? (&pass_cnt) : (&fail_cnt);
   assign total_nx = {1'b0, pass_cnt} + {1'b0, fail_cnt} + {{CNT_W{1'b0}}, ~sat_hit};

   always_comb begin
      state_nx = state;
      if (start) begin
         state_nx = ST_RUN;
      end else begin
         case (state)
            ST_RUN:    if (vif.vec_valid) state_nx = ST_SETTLE;
            ST_SETTLE: if (scnt == SETTLE_LAST) state_nx = ST_CHECK;
            ST_CHECK: begin
               if (!match && stop_on_fail)
                  state_nx = ST_HALT;
               else if ((num_vectors != '0) && (total_nx == {1'b0, num_vectors}))
                  state_nx = ST_DONE;
               else
                  state_nx = ST_RUN;
            end
            default: state_nx = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         ready_q <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         halted  <= 1'b0;
      end else begin
         state   <= state_nx;
         ready_q <= (state_nx == ST_RUN);
         busy    <= (state_nx == ST_RUN) || (state_nx == ST_SETTLE) || (state_nx == ST_CHECK);
         done    <= (state_nx == ST_DONE);
         halted  <= (state_nx == ST_HALT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_h    <= '0;
         b_h    <= '0;
         cin_h  <= 1'b0;
         s_h    <= '0;
         cout_h <= 1'b0;
         scnt   <= '0;
      end else begin
         if (accept) begin
            a_h   <= vif.a;
            b_h   <= vif.b;
            cin_h <= vif.cin;
            scnt  <= '0;
         end
         // The adder result is sampled on the edge that leaves SETTLE.
         if ((state == ST_SETTLE) && !start) begin
            if (scnt == SETTLE_LAST) begin
               s_h    <= vif.s;
               cout_h <= vif.cout;
            end else begin
               scnt <= scnt + SCW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_a    <= '0;
         fail_b    <= '0;
         fail_cin  <= 1'b0;
         fail_s    <= '0;
         fail_cout <= 1'b0;
         fail_seen <= 1'b0;
      end else if (start) begin
         fail_a    <= '0;
         fail_b    <= '0;
         fail_cin  <= 1'b0;
         fail_s    <= '0;
         fail_cout <= 1'b0;
         fail_seen <= 1'b0;
      end else if (fail_inc && !fail_seen) begin
         fail_a    <= a_h;
         fail_b    <= b_h;
         fail_cin  <= cin_h;
         fail_s    <= s_h;
         fail_cout <= cout_h;
         fail_seen <= 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_pass_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start),
      .inc   (pass_inc),
      .q     (pass_cnt)
   );

   sat_counter #(.W(CNT_W)) u_fail_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start),
      .inc   (fail_inc),
      .q     (fail_cnt)
   );

endmodule

// File: tb/tb_cla_result_checker.sv
// Scoreboard bench: instance A (SETTLE=1, CNT_W=16) for functional cases,
// instance B (SETTLE=3, CNT_W=3) for sample timing, throughput and saturation.
module tb_cla_result_checker;

   localparam int W = 4;

   typedef struct {
      int pass; int fail;
      bit done; bit halted; bit fseen;
      int fa; int fb; int fcin; int fs; int fcout;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   // ---------------- instance A ----------------
   logic          a_start, a_stop, fault_a;
   logic [15:0]   a_nv;
   logic          a_busy, a_done, a_halted, a_fcin, a_fcout, a_fseen;
   logic [15:0]   a_pass, a_failc;
   logic [W-1:0]  a_fa, a_fb, a_fs;
   logic [W:0]    sum_a;
   cla_result_checker_if #(.WIDTH(W)) ifa ();

   assign sum_a    = {1'b0, ifa.a} + {1'b0, ifa.b} + {4'b0, ifa.cin};
   assign ifa.s    = fault_a ? '0 : sum_a[W-1:0];
   assign ifa.cout = fault_a ? 1'b0 : sum_a[W];

   cla_result_checker #(.WIDTH(W), .SETTLE(1), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .stop_on_fail(a_stop),
      .num_vectors(a_nv), .vif(ifa), .busy(a_busy), .done(a_done), .halted(a_halted),
      .pass_cnt(a_pass), .fail_cnt(a_failc), .fail_a(a_fa), .fail_b(a_fb),
      .fail_cin(a_fcin), .fail_s(a_fs), .fail_cout(a_fcout), .fail_seen(a_fseen)
   );

   // ---------------- instance B ----------------
   logic          b_start, b_stop;
   logic [2:0]    b_nv;
   logic          b_busy, b_done, b_halted, b_fcin, b_fcout, b_fseen;
   logic [2:0]    b_pass, b_failc;
   logic [W-1:0]  b_fa, b_fb, b_fs;
   cla_result_checker_if #(.WIDTH(W)) ifb ();

   cla_result_checker #(.WIDTH(W), .SETTLE(3), .CNT_W(3)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .stop_on_fail(b_stop),
      .num_vectors(b_nv), .vif(ifb), .busy(b_busy), .done(b_done), .halted(b_halted),
      .pass_cnt(b_pass), .fail_cnt(b_failc), .fail_a(b_fa), .fail_b(b_fb),
      .fail_cin(b_fcin), .fail_s(b_fs), .fail_cout(b_fcout), .fail_seen(b_fseen)
   );

   exp_t qa[$];
   exp_t qb[$];
   exp_t ma, ea, eb;
   int   mb_pass;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout waiting for DUT (t=%0t)", name, $time);
   endtask

   // ---------------- monitors ----------------
   bit a_prev = 1'b0;
   always @(negedge clk) begin
      if (a_prev && (ifa.ready || a_done || a_halted)) begin
         if (qa.size() == 0) begin
            timeout("a_unexpected_result");
         end else begin
            ea = qa.pop_front();
            chk("a_pass_cnt", a_pass, ea.pass);
            chk("a_fail_cnt", a_failc, ea.fail);
            chk("a_done", a_done, ea.done);
            chk("a_halted", a_halted, ea.halted);
            chk("a_fail_seen", a_fseen, ea.fseen);
            chk("a_fail_a", a_fa, ea.fa);
            chk("a_fail_b", a_fb, ea.fb);
            chk("a_fail_cin", a_fcin, ea.fcin);
            chk("a_fail_s", a_fs, ea.fs);
            chk("a_fail_cout", a_fcout, ea.fcout);
         end
      end
      a_prev <= rst_n && a_busy && !ifa.ready;
   end

   bit b_prev = 1'b0;
   always @(negedge clk) begin
      if (b_prev && (ifb.ready || b_done || b_halted)) begin
         if (qb.size() == 0) begin
            timeout("b_unexpected_result");
         end else begin
            eb = qb.pop_front();
            chk("b_pass_cnt", b_pass, eb.pass);
            chk("b_fail_cnt", b_failc, eb.fail);
         end
      end
      b_prev <= rst_n && b_busy && !ifb.ready;
   end

   // ---------------- model / drivers ----------------
   task automatic model_clear_a();
      ma = '{pass: 0, fail: 0, done: 0, halted: 0, fseen: 0,
             fa: 0, fb: 0, fcin: 0, fs: 0, fcout: 0};
   endtask

   task automatic start_a();
      a_start = 1'b1;
      model_clear_a();
      @(posedge clk); #1;
      a_start = 1'b0;
   endtask

   task automatic wait_rdy_a(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ifa.ready) begin ok = 1'b1; break; end
      end
      if (!ok) timeout("a_ready");
   endtask

   task automatic wait_end_a(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (a_done || a_halted) begin ok = 1'b1; break; end
      end
      if (!ok) timeout(name);
   endtask

   task automatic drive_a(input int av, input int bv, input int cv, input bit flt);
      bit ok;
      int sum, obs;
      wait_rdy_a(ok);
      if (!ok) return;
      ifa.a = 4'(av); ifa.b = 4'(bv); ifa.cin = 1'(cv);
      fault_a = flt;
      ifa.vec_valid = 1'b1;
      sum = av + bv + cv;
      obs = flt ? 0 : sum;
      if (obs == sum) begin
         if (ma.pass < 65535) ma.pass++;
      end else begin
         if (ma.fail < 65535) ma.fail++;
         if (!ma.fseen) begin
            ma.fseen = 1; ma.fa = av; ma.fb = bv; ma.fcin = cv;
            ma.fs = obs % 16; ma.fcout = obs / 16;
         end
      end
      ma.halted = (obs != sum) && a_stop;
      ma.done   = !ma.halted && (a_nv != 0) && ((ma.pass + ma.fail) == int'(a_nv));
      qa.push_back(ma);
      @(posedge clk); #1;
      ifa.vec_valid = 1'b0;
   endtask

   task automatic check_reset_a(input string tag);
      chk({tag, "_ready"}, ifa.ready, 0);
      chk({tag, "_busy"}, a_busy, 0);
      chk({tag, "_done"}, a_done, 0);
      chk({tag, "_halted"}, a_halted, 0);
      chk({tag, "_fail_seen"}, a_fseen, 0);
      chk({tag, "_pass_cnt"}, a_pass, 0);
      chk({tag, "_fail_cnt"}, a_failc, 0);
      chk({tag, "_fail_a"}, a_fa, 0);
      chk({tag, "_fail_b"}, a_fb, 0);
      chk({tag, "_fail_cin"}, a_fcin, 0);
      chk({tag, "_fail_s"}, a_fs, 0);
      chk({tag, "_fail_cout"}, a_fcout, 0);
   endtask

   // B: vec_valid held high; the correct sum is present only in the cycle
   // ending at the third edge after accept, so any other sample point fails.
   task automatic run_b(input int n);
      int last = 0;
      logic [W:0] good;
      bit ok;
      for (int i = 0; i < n; i++) begin
         ok = 1'b0;
         for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (ifb.ready) begin ok = 1'b1; break; end
         end
         if (!ok) begin timeout("b_ready"); return; end
         ifb.a = 4'($urandom_range(0, 15));
         ifb.b = 4'($urandom_range(0, 15));
         ifb.cin = 1'($urandom_range(0, 1));
         good = 5'(int'(ifb.a) + int'(ifb.b) + int'(ifb.cin));
         mb_pass = (mb_pass < 7) ? mb_pass + 1 : 7;
         qb.push_back('{pass: mb_pass, fail: 0, done: 0, halted: 0, fseen: 0,
                        fa: 0, fb: 0, fcin: 0, fs: 0, fcout: 0});
         @(posedge clk); #1;
         if (i > 0) chk("b_accept_spacing", cyc - last, 5);
         last = cyc;
         {ifb.cout, ifb.s} = good + 5'd1;
         @(posedge clk); @(posedge clk); #1;
         {ifb.cout, ifb.s} = good;
         @(posedge clk); #1;
         {ifb.cout, ifb.s} = good + 5'd1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int v2a;
      bit ok;
      rst_n = 1'b0;
      a_start = 0; a_stop = 0; a_nv = '0; fault_a = 0;
      ifa.vec_valid = 0; ifa.a = '0; ifa.b = '0; ifa.cin = 0;
      b_start = 0; b_stop = 0; b_nv = '0;
      ifb.vec_valid = 0; ifb.a = '0; ifb.b = '0; ifb.cin = 0; ifb.s = '0; ifb.cout = 0;
      model_clear_a();
      mb_pass = 0;
      repeat (3) @(posedge clk); #1;
      check_reset_a("reset");
      chk("reset_b_ready", ifb.ready, 0);
      chk("reset_b_pass", b_pass, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // three good vectors, bounded run
      a_nv = 16'd3; a_stop = 0;
      start_a();
      drive_a(3, 4, 0, 0);
      drive_a(15, 1, 0, 0);
      drive_a(15, 15, 1, 0);
      wait_end_a("t1_end");
      chk("t1_done", a_done, 1);
      chk("t1_ready", ifa.ready, 0);
      chk("t1_pass", a_pass, 3);

      // stop on first mismatch
      a_nv = 16'd0; a_stop = 1;
      start_a();
      for (int i = 0; i < 3; i++)
         drive_a($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), 0);
      drive_a(5, 6, 1, 1);
      wait_end_a("t2_end");
      chk("t2_halted", a_halted, 1);
      chk("t2_fail_cnt", a_failc, 1);
      chk("t2_fail_a", a_fa, 5);
      chk("t2_fail_b", a_fb, 6);

      // run through two faults, first-fail record holds vector 2
      a_nv = 16'd4; a_stop = 0;
      start_a();
      v2a = $urandom_range(1, 15);
      drive_a($urandom_range(0, 15), $urandom_range(0, 15), 0, 0);
      drive_a(v2a, $urandom_range(0, 15), 1, 1);
      drive_a($urandom_range(0, 15), $urandom_range(0, 15), 1, 0);
      drive_a($urandom_range(1, 15), $urandom_range(0, 15), 0, 1);
      wait_end_a("t3_end");
      chk("t3_done", a_done, 1);
      chk("t3_pass", a_pass, 2);
      chk("t3_fail", a_failc, 2);
      chk("t3_fail_a", a_fa, v2a);

      // random mix
      a_nv = 16'd24; a_stop = 0;
      start_a();
      for (int i = 0; i < 24; i++)
         drive_a($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
                 ($urandom_range(0, 3) == 0));
      wait_end_a("t4_end");
      chk("t4_done", a_done, 1);

      // start during SETTLE aborts the vector and clears
      a_nv = 16'd0; a_stop = 0;
      start_a();
      drive_a(9, 9, 0, 0);
      drive_a(2, 3, 1, 1);
      wait_rdy_a(ok);
      ifa.a = 4'd1; ifa.b = 4'd2; ifa.cin = 0; fault_a = 1; ifa.vec_valid = 1;
      @(posedge clk); #1;
      ifa.vec_valid = 0;
      a_start = 1;
      model_clear_a();
      qa.push_back(ma);
      @(posedge clk); #1;
      a_start = 0;
      chk("t5_ready", ifa.ready, 1);
      chk("t5_pass", a_pass, 0);
      chk("t5_fail_seen", a_fseen, 0);

      // reset while in CHECK
      drive_a(7, 8, 0, 1);
      wait_rdy_a(ok);
      ifa.a = 4'd4; ifa.b = 4'd4; ifa.cin = 0; fault_a = 0; ifa.vec_valid = 1;
      @(posedge clk); #1;
      ifa.vec_valid = 0;
      @(posedge clk); #1;
      chk("t6_busy_before_rst", a_busy, 1);
      rst_n = 1'b0;
      #1;
      check_reset_a("t6_async");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      start_a();
      chk("t6_ready", ifa.ready, 1);
      chk("t6_pass", a_pass, 0);
      chk("t6_fail", a_failc, 0);

      // SETTLE=3 timing, throughput and 3-bit saturation
      b_nv = 3'd0; b_stop = 0;
      ifb.vec_valid = 1;
      b_start = 1;
      @(posedge clk); #1;
      b_start = 0;
      run_b(10);
      ok = 1'b0;
      for (int j = 0; j < 30; j++) begin
         @(negedge clk);
         if (ifb.ready) begin ok = 1'b1; break; end
      end
      if (!ok) timeout("b_final_ready");
      ifb.vec_valid = 0;
      chk("b_pass_saturated", b_pass, 7);
      chk("b_fail_zero", b_failc, 0);
      chk("b_not_done", b_done, 0);

      repeat (3) @(posedge clk);
      chk("qa_empty", qa.size(), 0);
      chk("qb_empty", qb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cla_result_checker.md
# cla_result_checker

Synthesizable response checker that sits on the output side of the `cla_adder_4` datapath and consumes the vectors a stimulus source drives into it. Each accepted vector (A, B, Cin) is held, the adder is given a programmable settle time, then S/Cout are sampled and compared against a golden sum. Pass and fail counts are kept, and the first failing vector is latched. It is used for on-board self-test and as the scoreboard end of the adder test harness.

## Interface
Parameters:
- WIDTH, 4, operand width of the adder under check
- SETTLE, 1, cycles between vector capture and result sample (legal range 1..15)
- CNT_W, 16, width of the pass/fail/total counters

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse: clear counters and first-fail record, enter RUN
- stop_on_fail  in  1  when 1, halt at the first mismatch
- num_vectors  in  CNT_W  vectors to check before DONE; 0 = unbounded
- vec_valid  in  1  source presents a vector on a/b/cin
- a, b  in  WIDTH  operands driven to the adder
- cin  in  1  carry-in driven to the adder
- s  in  WIDTH  adder sum output
- cout  in  1  adder carry output
- ready  out  1  checker accepts a vector this cycle
- busy  out  1  state is not IDLE/DONE/HALT
- done  out  1  num_vectors reached without halt
- halted  out  1  stopped on mismatch
- pass_cnt, fail_cnt  out  CNT_W  saturating counts
- fail_a, fail_b  out  WIDTH  operands of the first failing vector
- fail_cin  out  1  carry-in of the first failing vector
- fail_s  out  WIDTH  sum observed at the first failure
- fail_cout  out  1  carry observed at the first failure
- fail_seen  out  1  fail_* fields are valid

## Operation
- States: IDLE, RUN, SETTLE, CHECK, DONE, HALT.
- IDLE: ready=0. A `start` pulse clears all counters, clears the fail_* record and fail_seen, and moves to RUN.
- RUN: ready=1. When vec_valid&ready is high, capture a, b, cin into held registers and move to SETTLE.
- SETTLE: count SETTLE−1 further cycles, then move to CHECK. The source must hold a/b/cin stable while ready=0; the checker uses its held copy for the golden model.
- CHECK:
  - Compute exp = {1'b0,a_h} + {1'b0,b_h} + cin_h, which is WIDTH+1 bits wide with no truncation.
  - If {cout,s} equals exp, increment pass_cnt. Otherwise increment fail_cnt and, if fail_seen=0, latch fail_* and set fail_seen.
  - Next state: HALT if there was a mismatch and stop_on_fail=1; else DONE if num_vectors≠0 and pass_cnt+fail_cnt (after the update) equals num_vectors; else RUN.
- DONE/HALT: ready=0, and all counters and the fail_* record are held. `start` restarts exactly as it does from IDLE.
- `start` in RUN, SETTLE or CHECK: abort the current vector without counting it, clear, and re-enter RUN.
- Counters saturate at 2^CNT_W−1 and never wrap. The total uses a CNT_W+1-bit internal sum.
- A `vec_valid` outside RUN is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - ready, busy, done, halted, fail_seen = 0.
  - pass_cnt, fail_cnt = 0.
  - fail_a, fail_b, fail_cin, fail_s, fail_cout = 0.
- Accept at edge k. SETTLE state occupies edges k+1..k+SETTLE−1, CHECK is evaluated at edge k+SETTLE, and s/cout are sampled at that edge.
- Counter, fail_* and done/halted updates are visible after edge k+SETTLE+1. ready is high again in that same cycle when the next state is RUN.
- Throughput is one vector per SETTLE+2 cycles.
- All outputs are registered; ready is decoded from the state register only.
- Reset asserted mid-run drops to IDLE immediately (asynchronous). Counters are lost.

## Structure
- Package cla_chk_pkg holds:
  - the state enum typedef `chk_state_t`
  - the constant `SETTLE_MAX = 15`
- One sub-module, `sat_counter` (parameter W; ports: clk, rst_n, clr, inc, q), instantiated twice, for pass_cnt and fail_cnt.
- The golden adder is an inline behavioural `+` and is not instantiated.

## Test plan
- Reset, then start with num_vectors=3, SETTLE=1, and vectors (3,4,0), (15,1,0), (15,15,1) driven into a correct adder → pass_cnt=3, fail_cnt=0, done=1 after the third CHECK, ready=0.
- Adder output forced to s=0, cout=0 on vector (5,6,1) with stop_on_fail=1 → halted=1, fail_cnt=1, fail_a=5, fail_b=6, fail_cin=1, fail_s=0, fail_cout=0.
- Same fault with stop_on_fail=0 and num_vectors=4, fault on vectors 2 and 4 → fail_cnt=2, pass_cnt=2; fail_* holds vector 2; done=1.
- SETTLE=3 with vec_valid held high continuously → ready pulses exactly every 5 cycles; s is sampled 3 edges after the accept edge.
- CNT_W=3, num_vectors=0, 10 passing vectors → pass_cnt saturates at 7 and never wraps.
- start pulsed while in SETTLE, and rst_n dropped while in CHECK → the vector is not counted and RUN is re-entered with counters 0; reset returns all outputs to their reset values asynchronously.
